// File: rtl/icache_req_arb.sv
// -----------------------------------------------------------------------------
// icache_req_arb
//
// Shares one instruction-cache request/response port between NUM_REQS fetch
// requesters. Requests are arbitrated round-robin and the winner is captured in
// a one-entry output register. Its tag is extended with the requester index
// in the LSBs. Responses are routed back combinationally by that index.
// Per-requester pending counters cap in-flight fetches and feed `busy`.
//
// Parameters
//   NUM_REQS     number of requesters (>= 1)
//   ADDR_WIDTH   word address width
//   DATA_WIDTH   instruction data width
//   TAG_WIDTH    requester-side tag width
//   MAX_PENDING  in-flight fetch limit per requester (>= 1)
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   req_valid_in/addr_in/tag_in    packed per-requester requests (slice i)
//   req_ready_out                  per-requester accept
//   req_valid/addr/tag_out         registered icache request, tag = {tag, idx}
//   req_ready_in                   icache accept
//   rsp_valid/data/tag_in          icache response
//   rsp_ready_out                  response accept toward the icache
//   rsp_valid_out                  per-requester response valid
//   rsp_data_out, rsp_tag_out      response data/tag broadcast to all slices
//   rsp_ready_in                   per-requester response ready
//   busy                           request held or any fetch outstanding
//
// Optional feature: define ICACHE_ARB_PERF_EN to add the 64-bit output
// perf_stall_cycles, counting cycles with a valid request but no accept.
// -----------------------------------------------------------------------------
module icache_req_arb #(
  parameter int NUM_REQS    = 2,
  parameter int ADDR_WIDTH  = 30,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 4,
  localparam int IDX_BITS   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNT_BITS   = $clog2(MAX_PENDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic [NUM_REQS-1:0]              req_valid_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag_in,
  output logic [NUM_REQS-1:0]              req_ready_out,

  output logic                             req_valid_out,
  output logic [ADDR_WIDTH-1:0]            req_addr_out,
  output logic [TAG_WIDTH+IDX_BITS-1:0]    req_tag_out,
  input  logic                             req_ready_in,

  input  logic                             rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]            rsp_data_in,
  input  logic [TAG_WIDTH+IDX_BITS-1:0]    rsp_tag_in,
  output logic                             rsp_ready_out,

  output logic [NUM_REQS-1:0]              rsp_valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_data_out,
  output logic [NUM_REQS*TAG_WIDTH-1:0]    rsp_tag_out,
  input  logic [NUM_REQS-1:0]              rsp_ready_in,

  output logic                             busy
`ifdef ICACHE_ARB_PERF_EN
  ,
  output logic [63:0]                      perf_stall_cycles
`endif
);

  // Output register
  logic                          out_valid;
  logic [ADDR_WIDTH-1:0]         out_addr;
  logic [TAG_WIDTH+IDX_BITS-1:0] out_tag;

  // Arbitration state and per-requester fetch credits
  logic [IDX_BITS-1:0]           rr_ptr;
  logic [CNT_BITS-1:0]           pending [NUM_REQS];

  logic                          load;
  logic [NUM_REQS-1:0]           eligible;
  logic                          found;
  logic                          accept;
  logic [IDX_BITS-1:0]           grant_idx;
  logic [IDX_BITS-1:0]           rr_next;
  logic [ADDR_WIDTH-1:0]         grant_addr;
  logic [TAG_WIDTH-1:0]          grant_tag;
  logic [IDX_BITS-1:0]           rsp_sel;
  logic [NUM_REQS-1:0]           pend_inc;
  logic [NUM_REQS-1:0]           pend_dec;
  logic [NUM_REQS-1:0]           pend_nz;

  // The register can take a new grant when empty or when it drains this cycle.
  assign load = !out_valid || req_ready_in;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = req_valid_in[i] && (pending[i] < CNT_BITS'(MAX_PENDING));
      pend_nz[i]  = (pending[i] != '0);
    end
  end

  // Round-robin scan: first look at indices >= rr_ptr, then wrap to those
  // below it. Constant loop indices keep the selection free of variable
  // part-selects.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    found      = 1'b0;
    grant_idx  = '0;
    grant_addr = '0;
    grant_tag  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!found && eligible[i] && (IDX_BITS'(i) >= rr_ptr)) begin
        found      = 1'b1;
        grant_idx  = IDX_BITS'(i);
        grant_addr = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_tag  = req_tag_in[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!found && eligible[i] && (IDX_BITS'(i) < rr_ptr)) begin
        found      = 1'b1;
        grant_idx  = IDX_BITS'(i);
        grant_addr = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        grant_tag  = req_tag_in[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign accept  = load && found;
  assign rr_next = (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready_out[i] = accept && (grant_idx == IDX_BITS'(i));
    end
  end

  assign req_valid_out = out_valid;
  assign req_addr_out  = out_addr;
  assign req_tag_out   = out_tag;

  // Response routing. An index with no matching requester (NUM_REQS not a
  // power of two) raises no valid and is accepted, so it is dropped.
  assign rsp_sel = rsp_tag_in[IDX_BITS-1:0];

  always_comb begin
    rsp_valid_out = '0;
    rsp_ready_out = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_sel == IDX_BITS'(i)) begin
        rsp_valid_out[i] = rsp_valid_in;
        rsp_ready_out    = rsp_ready_in[i];
      end
    end
  end

  assign rsp_data_out = {NUM_REQS{rsp_data_in}};
  assign rsp_tag_out  = {NUM_REQS{rsp_tag_in[TAG_WIDTH+IDX_BITS-1 -: TAG_WIDTH]}};

  assign pend_inc = req_ready_out;
  assign pend_dec = rsp_valid_out & rsp_ready_in;

  assign busy = out_valid || (|pend_nz);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  // NOTE: the pending array is control state that must start at zero, so it is
  // cleared on reset; the address/tag payload below is qualified by out_valid
  // and needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        pending[i] <= '0;
      end
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        rr_ptr    <= rr_next;
      end else if (req_ready_in) begin
        out_valid <= 1'b0;
      end
      for (int i = 0; i < NUM_REQS; i++) begin
        case ({pend_inc[i], pend_dec[i]})
          2'b10:   pending[i] <= pending[i] + 1'b1;
          // A late response after reset must not wrap the counter.
          2'b01:   if (pending[i] != '0) pending[i] <= pending[i] - 1'b1;
          default: pending[i] <= pending[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_addr <= grant_addr;
      out_tag  <= {grant_tag, grant_idx};
    end
  end

`ifdef ICACHE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
    end else if ((|req_valid_in) && !accept) begin
      perf_stall_cycles <= perf_stall_cycles + 64'd1;
    end
  end
`endif

endmodule
